// File: rtl/cpu_instruction_prefetch.sv
// Instruction prefetcher: fetches sequential words from memory into the instruction FIFO using credits.
// Optional perf counters (stall_cycles, flush_count) are built when PREFETCH_PERF_COUNTERS_EN is defined.
module cpu_instruction_prefetch #(
  parameter int unsigned FIFO_DEPTH_BITS = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [15:0] PC_RESET        = 16'h0000
) (
  input  logic        CLK,
  input  logic        RSTb,
  input  logic        enable,
  input  logic        load_pc,
  input  logic [15:0] new_pc,
  output logic        mem_request,
  output logic [15:0] mem_addr,
  input  logic        mem_grant,
  input  logic        mem_valid,
  input  logic [15:0] mem_data,
  output logic        fifo_wr,
  output logic [31:0] fifo_data,
  input  logic        fifo_rd,
  output logic        fifo_flush
`ifdef PREFETCH_PERF_COUNTERS_EN
  ,
  output logic [15:0] stall_cycles,
  output logic [7:0]  flush_count
`endif
);

  localparam int unsigned OCC_W   = FIFO_DEPTH_BITS + 1;
  localparam int unsigned OUT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SUM_W   = OCC_W + OUT_W;
  localparam int unsigned CREDITS = 1 << FIFO_DEPTH_BITS;

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_e;

  state_e             state_q, state_d;
  logic [15:0]        fetch_pc_q, fetch_pc_d;
  logic [15:0]        resp_pc_q, resp_pc_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [OUT_W-1:0]   outst_q, outst_d;
  logic [OUT_W-1:0]   discard_q, discard_d;
  logic               fifo_wr_q, fifo_wr_d;
  logic [31:0]        fifo_data_q, fifo_data_d;
  logic               fifo_flush_q, fifo_flush_d;

  logic               grant;
  logic               redirect;
  logic               accept;
  logic               rd_ok;
  logic               rsp_ret;
  logic [OUT_W-1:0]   outst_after;

  // Credits cover both FIFO entries and responses still in flight.
  assign mem_request = (state_q == FETCH) && enable && !load_pc &&
                       (outst_q < OUT_W'(MAX_OUTSTANDING)) &&
                       ((SUM_W'(occ_q) + SUM_W'(outst_q)) < SUM_W'(CREDITS));
  assign mem_addr    = fetch_pc_q;
  assign fifo_wr     = fifo_wr_q;
  assign fifo_data   = fifo_data_q;
  assign fifo_flush  = fifo_flush_q;

  assign grant       = mem_request && mem_grant;
  assign redirect    = load_pc && (state_q != IDLE);
  assign accept      = mem_valid && (discard_q == '0) && !load_pc;
  assign rd_ok       = fifo_rd && (occ_q != '0);
  assign rsp_ret     = mem_valid && (outst_q != '0);
  assign outst_after = outst_q - OUT_W'(rsp_ret);

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    resp_pc_d    = resp_pc_q;
    occ_d        = occ_q + OCC_W'(accept) - OCC_W'(rd_ok);
    outst_d      = outst_after + OUT_W'(grant);
    discard_d    = discard_q;
    fifo_wr_d    = accept;
    fifo_data_d  = fifo_data_q;
    fifo_flush_d = redirect;

    if (accept) begin
      fifo_data_d = {resp_pc_q, mem_data};
      resp_pc_d   = resp_pc_q + 16'd1;
    end
    if (grant) begin
      fetch_pc_d = fetch_pc_q + 16'd1;
    end
    if (mem_valid && (discard_q != '0)) begin
      discard_d = discard_q - OUT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (load_pc) begin
          fetch_pc_d = new_pc;
          resp_pc_d  = new_pc;
        end else if (enable) begin
          state_d = FETCH;
        end
      end
      FLUSH: begin
        if (discard_d == '0) state_d = FETCH;
      end
      default: ;
    endcase

    // Redirect: everything still in flight belongs to the old stream and is dropped.
    if (redirect) begin
      fetch_pc_d = new_pc;
      resp_pc_d  = new_pc;
      occ_d      = '0;
      discard_d  = outst_after;
      state_d    = (outst_after != '0) ? FLUSH : FETCH;
      fifo_wr_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_q      <= IDLE;
      fetch_pc_q   <= PC_RESET;
      resp_pc_q    <= PC_RESET;
      occ_q        <= '0;
      outst_q      <= '0;
      discard_q    <= '0;
      fifo_wr_q    <= 1'b0;
      fifo_data_q  <= '0;
      fifo_flush_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      resp_pc_q    <= resp_pc_d;
      occ_q        <= occ_d;
      outst_q      <= outst_d;
      discard_q    <= discard_d;
      fifo_wr_q    <= fifo_wr_d;
      fifo_data_q  <= fifo_data_d;
      fifo_flush_q <= fifo_flush_d;
    end
  end

`ifdef PREFETCH_PERF_COUNTERS_EN
  logic [15:0] stall_q;
  logic [7:0]  flush_cnt_q;
  logic        stall_inc;

  // A stall is a cycle where fetching is wanted but credits or the outstanding limit block it.
  assign stall_inc    = (state_q == FETCH) && enable && !load_pc && !mem_request;
  assign stall_cycles = stall_q;
  assign flush_count  = flush_cnt_q;

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      stall_q     <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_inc && (stall_q != '1)) stall_q <= stall_q + 16'd1;
      if (load_pc && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_instruction_prefetch.sv
// Bench for cpu_instruction_prefetch: a latency-configurable memory plus a stream/epoch reference model.
module tb_cpu_instruction_prefetch;

  localparam int unsigned DEPTH   = 16;
  localparam int unsigned MAX_OUT = 2;

  logic        CLK = 1'b0;
  logic        RSTb;
  logic        enable, load_pc, mem_grant, mem_valid, fifo_rd;
  logic [15:0] new_pc, mem_data;
  logic        mem_request, fifo_wr, fifo_flush;
  logic [15:0] mem_addr;
  logic [31:0] fifo_data;

  cpu_instruction_prefetch dut (
    .CLK(CLK), .RSTb(RSTb), .enable(enable), .load_pc(load_pc), .new_pc(new_pc),
    .mem_request(mem_request), .mem_addr(mem_addr), .mem_grant(mem_grant),
    .mem_valid(mem_valid), .mem_data(mem_data), .fifo_wr(fifo_wr),
    .fifo_data(fifo_data), .fifo_rd(fifo_rd), .fifo_flush(fifo_flush)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] addr;
    int          tag;
    int          due;
  } ent_t;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          lat = 1;
  int          grant_pct = 100;
  logic [15:0] m_fetch;
  int          epoch;
  int          occ;
  bit          started;
  ent_t        pend[$];
  int          wr_count;
  logic [15:0] wr_log[$];

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  // Requests from an abandoned stream are still owed by memory but must not be written.
  function automatic bit old_pending();
    foreach (pend[i]) if (pend[i].tag != epoch) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_mem_request", 32'(mem_request), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0000);
    chk("rst_fifo_wr", 32'(fifo_wr), 32'd0);
    chk("rst_fifo_data", fifo_data, 32'd0);
    chk("rst_fifo_flush", 32'(fifo_flush), 32'd0);
  endtask

  task automatic model_reset();
    pend.delete();
    wr_log.delete();
    m_fetch   = 16'h0000;
    epoch     = 0;
    occ       = 0;
    started   = 1'b0;
    wr_count  = 0;
    mem_valid = 1'b0;
    mem_grant = 1'b0;
    mem_data  = 16'h0000;
    enable    = 1'b0;
    load_pc   = 1'b0;
    fifo_rd   = 1'b0;
    new_pc    = 16'h0000;
  endtask

  // One clock: check request side before the edge, advance the model, check FIFO side after it.
  task automatic tick();
    bit          g, v, ld, rd, en, rd_ok, exp_wr, exp_flush, exp_req;
    logic [15:0] npc;
    logic [31:0] exp_data;
    ent_t        h;
    #2;
    exp_req = started && enable && !load_pc && !old_pending() &&
              (pend.size() < MAX_OUT) && (occ + pend.size() < DEPTH);
    chk("mem_addr", 32'(mem_addr), 32'(m_fetch));
    chk("mem_request", 32'(mem_request), 32'(exp_req));
    g = mem_request && mem_grant;
    v = mem_valid; ld = load_pc; rd = fifo_rd; en = enable; npc = new_pc;
    @(posedge CLK);
    cyc++;
    #1;
    exp_wr   = 1'b0;
    exp_data = '0;
    rd_ok    = rd && (occ > 0);
    if (v && pend.size() > 0) begin
      h = pend.pop_front();
      if (h.tag == epoch && !ld) begin
        exp_wr   = 1'b1;
        exp_data = {h.addr, mem_word(h.addr)};
        occ++;
      end
    end
    if (rd_ok) occ--;
    if (g) begin
      pend.push_back('{m_fetch, epoch, cyc + lat});
      m_fetch = m_fetch + 16'd1;
    end
    exp_flush = ld && started;
    if (ld) begin
      m_fetch = npc;
      if (started) begin
        epoch++;
        occ = 0;
      end
    end else if (!started && en) begin
      started = 1'b1;
    end
    chk("fifo_wr", 32'(fifo_wr), 32'(exp_wr));
    chk("fifo_flush", 32'(fifo_flush), 32'(exp_flush));
    if (exp_wr) chk("fifo_data", fifo_data, exp_data);
    if (fifo_wr) begin
      wr_count++;
      wr_log.push_back(fifo_data[31:16]);
    end
    mem_valid = (pend.size() > 0) && (pend[0].due <= cyc + 1);
    mem_data  = mem_valid ? mem_word(pend[0].addr) : 16'($urandom);
    mem_grant = ($urandom_range(0, 99) < grant_pct);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    bit prev_ld;
    int n;
    RSTb = 1'b0;
    model_reset();
    #1;
    check_reset_outputs();
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RSTb = 1'b1;

    // Sequential fetch with single-cycle memory, no reads: fills exactly the credit limit.
    grant_pct = 100; lat = 1; mem_grant = 1'b1;
    enable = 1'b1;
    repeat (40) tick();
    chk("fill_count", 32'(wr_count), 32'd16);
    chk("fill_pc0", 32'(wr_log[0]), 32'h0000);
    chk("fill_pc1", 32'(wr_log[1]), 32'h0001);
    chk("full_no_request", 32'(mem_request), 32'd0);

    // One read frees one credit; the 17th write carries PC 0x0010.
    fifo_rd = 1'b1;
    tick();
    fifo_rd = 1'b0;
    n = 0;
    while (wr_count < 17 && n < 10) begin tick(); n++; end
    chk("write17_seen", 32'(wr_count), 32'd17);
    chk("write17_pc", 32'(wr_log[wr_log.size()-1]), 32'h0010);

    // Read and response on the same edge at occupancy 15.
    fifo_rd = 1'b1; tick();
    fifo_rd = 1'b0; tick();
    fifo_rd = 1'b1; tick();
    fifo_rd = 1'b0; tick();
    tick();

    // Drain.
    enable = 1'b0; fifo_rd = 1'b1;
    repeat (24) tick();

    // Redirect with two requests outstanding at latency 3.
    lat = 3; enable = 1'b1;
    n = 0;
    while (pend.size() < 2 && n < 20) begin tick(); n++; end
    chk("two_outstanding", 32'(pend.size()), 32'd2);
    wr_log.delete();
    load_pc = 1'b1; new_pc = 16'h1234;
    tick();
    load_pc = 1'b0;
    n = 0;
    while (wr_log.size() < 1 && n < 30) begin tick(); n++; end
    chk("redirect_first_pc", (wr_log.size() > 0) ? 32'(wr_log[0]) : 32'hDEAD, 32'h1234);

    // PC wrap after redirect.
    lat = 1;
    repeat (4) tick();
    wr_log.delete();
    load_pc = 1'b1; new_pc = 16'hFFFE;
    tick();
    load_pc = 1'b0;
    n = 0;
    while (wr_log.size() < 3 && n < 30) begin tick(); n++; end
    chk("wrap_count", 32'(wr_log.size() >= 3), 32'd1);
    if (wr_log.size() >= 3) begin
      chk("wrap_pc0", 32'(wr_log[0]), 32'hFFFE);
      chk("wrap_pc1", 32'(wr_log[1]), 32'hFFFF);
      chk("wrap_pc2", 32'(wr_log[2]), 32'h0000);
    end

    // Random traffic: enable, reads, grants, latency and redirects.
    prev_ld = 1'b0;
    grant_pct = 70;
    for (int i = 0; i < 600; i++) begin
      enable  = ($urandom_range(0, 7) != 0);
      fifo_rd = ($urandom_range(0, 99) < 45);
      lat     = $urandom_range(1, 4);
      load_pc = !prev_ld && ($urandom_range(0, 99) < 4);
      new_pc  = 16'($urandom);
      prev_ld = load_pc;
      tick();
    end
    load_pc = 1'b0;

    // Asynchronous reset with two responses in flight.
    grant_pct = 100; lat = 4; enable = 1'b1; fifo_rd = 1'b1;
    n = 0;
    while (pend.size() < 2 && n < 20) begin tick(); n++; end
    chk("pre_reset_outstanding", 32'(pend.size()), 32'd2);
    #2;
    RSTb = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    @(posedge CLK);
    @(posedge CLK);
    cyc += 2;
    #1;
    RSTb = 1'b1;
    grant_pct = 100; lat = 1; mem_grant = 1'b1; enable = 1'b1; fifo_rd = 1'b1;
    n = 0;
    while (wr_log.size() < 2 && n < 20) begin tick(); n++; end
    chk("restart_count", 32'(wr_log.size() >= 2), 32'd1);
    if (wr_log.size() >= 2) begin
      chk("restart_pc0", 32'(wr_log[0]), 32'h0000);
      chk("restart_pc1", 32'(wr_log[1]), 32'h0001);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
